lsu_issue_sequencer: RTL and testbench
======================================

# lsu_issue_sequencer

Program-driven instruction issue controller for the CVA6 processor shim's instruction port. It holds a short program in a local buffer and issues it in order over a valid/ready handshake. After each load or store it inserts one bubble so the LSU sees at most one memory op in flight from the feeder. A stall watchdog flags a shim that stops accepting instructions; the formal and simulation harnesses instantiate one sequencer per shim copy.

## Interface
- DEPTH, 4, program buffer entries
- IDX_W, 2, index width; DEPTH == 2**IDX_W
- MAX_STALL, 16, consecutive unaccepted-valid cycles before error; range 1..255

- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  reset, synchronous and active-high
- prog_we_i  in  1  program buffer write strobe
- prog_addr_i  in  IDX_W  write index
- prog_data_i  in  32  instruction word to write
- prog_len_i  in  IDX_W+1  number of entries to issue, 0..DEPTH, sampled with start_i
- start_i  in  1  begin issuing from entry 0
- instr_o  out  32  instruction to shim; 0 when instr_valid_o low
- instr_valid_o  out  1  instruction valid to shim
- instr_ready_i  in  1  shim ready
- busy_o  out  1  in ISSUE or BUBBLE
- done_o  out  1  program fully issued (level)
- issued_cnt_o  out  IDX_W+1  instructions accepted this run
- mem_ops_o  out  IDX_W+1  loads and stores accepted this run
- stall_err_o  out  1  watchdog tripped (sticky)

## Operation
- FSM states: IDLE, ISSUE, BUBBLE, DONE, ERR.
- Reset: state IDLE, pc 0, counters 0, stall counter 0, all outputs 0. Buffer contents are not reset.
- prog_we_i is accepted only in IDLE and DONE and ignored elsewhere. A write at cycle t is readable at t+1.
- Memory op: instr[6:0] == 7'b0000011 (LOAD) or 7'b0100011 (STORE).
- IDLE/DONE + start_i:
  - Latch prog_len_i, clear pc, issued_cnt_o and mem_ops_o.
  - Go to ISSUE if length != 0, otherwise go to DONE.
  - A prog_len_i above DEPTH saturates to DEPTH.
- ISSUE:
  - instr_valid_o = 1 and instr_o = buf[pc].
  - Handshake = valid & ready. On handshake: pc++, issued_cnt_o++, and mem_ops_o++ if the instruction is a memory op.
  - After a handshake, next state is DONE if pc+1 == length. Otherwise it is BUBBLE if the accepted instruction was a memory op (see Configuration), otherwise ISSUE.
- BUBBLE: instr_valid_o = 0 for exactly one cycle, then ISSUE.
- DONE: done_o = 1 until start_i. start_i is also honoured in the DONE cycle itself.
- ERR: reached from ISSUE when the stall counter reaches MAX_STALL.
  - stall_err_o = 1, instr_valid_o = 0.
  - Leaves only on rst_i; start_i is ignored.
- Stall counter:
  - Increments each ISSUE cycle with valid & !ready.
  - Clears on handshake or on leaving ISSUE.
- Reset mid-run aborts immediately. No partial instruction remains valid in the next cycle.

## Timing
- Outputs are driven from registers only. There is no combinational path from instr_ready_i to instr_valid_o.
- start_i sampled at cycle t gives instr_valid_o = 1 at t+1.
- Valid/ready rule: once valid is raised, valid and instr_o stay stable until the handshake. Valid never drops without acceptance, except on rst_i or the ERR transition.
- Non-memory instructions issue back-to-back, one per cycle, when ready is held high.
- A memory op accepted at cycle t gives valid low at t+1 and the next instruction valid at t+2.
- Last handshake at cycle t gives done_o = 1 and busy_o = 0 at t+1.
- A shim that holds ready low from the first valid cycle causes stall_err_o to rise MAX_STALL+1 cycles after valid rises.

## Configuration
- LSU_SEQ_MEM_BUBBLE_EN defined: the BUBBLE state is used after every non-final memory op, as described above.
- LSU_SEQ_MEM_BUBBLE_EN undefined: BUBBLE is unreachable and memory ops issue back-to-back like ALU ops. mem_ops_o still counts.

## Test plan
- Load LW, SW, LW, ADDI (0x00002083, 0x00112023, 0x00022183, 0x00000093), length 4, ready held 1, bubble enabled -> valid pattern 1,0,1,0,1,0,1; done_o at the cycle after the 4th handshake; issued_cnt_o = 4; mem_ops_o = 3.
- Same program with the macro undefined -> four consecutive valid cycles; done_o one cycle after the last.
- Ready low for 3 cycles on entry 1 -> instr_o holds 0x00112023 with valid high throughout; handshake on the 4th cycle; no error.
- MAX_STALL = 4, ready held 0 -> stall_err_o rises 5 cycles after valid rises; valid drops; start_i ignored until rst_i.
- start_i with prog_len_i = 0 -> DONE the next cycle; valid never asserted; counters 0.
- rst_i during BUBBLE after entry 0 -> next cycle all outputs 0 and state IDLE; a fresh start reissues entry 0.

Source files
------------

// File: rtl/lsu_issue_sequencer.sv
// rtl/lsu_issue_sequencer.sv - program-driven instruction issue controller with memory-op bubble and stall watchdog
// Optional feature macro: LSU_SEQ_MEM_BUBBLE_EN (insert one idle cycle after each non-final load/store)
module lsu_issue_sequencer #(
    parameter int DEPTH     = 4,
    parameter int IDX_W     = 2,
    parameter int MAX_STALL = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             prog_we_i,
    input  logic [IDX_W-1:0] prog_addr_i,
    input  logic [31:0]      prog_data_i,
    input  logic [IDX_W:0]   prog_len_i,
    input  logic             start_i,
    output logic [31:0]      instr_o,
    output logic             instr_valid_o,
    input  logic             instr_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [IDX_W:0]   issued_cnt_o,
    output logic [IDX_W:0]   mem_ops_o,
    output logic             stall_err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_BUBBLE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [IDX_W:0] DEPTH_W     = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0] ONE_W       = (IDX_W+1)'(1);
    localparam logic [7:0]     MAX_STALL_W = 8'(MAX_STALL);
    localparam logic [6:0]     OPC_LOAD    = 7'b0000011;
    localparam logic [6:0]     OPC_STORE   = 7'b0100011;

`ifdef LSU_SEQ_MEM_BUBBLE_EN
    localparam bit BUBBLE_EN = 1'b1;
`else
    localparam bit BUBBLE_EN = 1'b0;
`endif

    state_t         state_q, state_d;
    logic [31:0]    buf_q [DEPTH];
    logic [IDX_W:0] pc_q, pc_d;
    logic [IDX_W:0] len_q, len_d;
    logic [IDX_W:0] issued_q, issued_d;
    logic [IDX_W:0] mem_q, mem_d;
    logic [7:0]     stall_q, stall_d;

    logic [31:0]    cur_instr;
    logic           cur_is_mem;
    logic [IDX_W:0] pc_inc;
    logic [IDX_W:0] len_sat;

    assign cur_instr  = buf_q[pc_q[IDX_W-1:0]];
    assign cur_is_mem = (cur_instr[6:0] == OPC_LOAD) || (cur_instr[6:0] == OPC_STORE);
    assign pc_inc     = pc_q + ONE_W;
    assign len_sat    = (prog_len_i > DEPTH_W) ? DEPTH_W : prog_len_i;

    // Program buffer: writable only while not running; contents survive reset
    always_ff @(posedge clk_i) begin
        if (prog_we_i && (state_q == S_IDLE || state_q == S_DONE)) begin
            buf_q[prog_addr_i] <= prog_data_i;
        end
    end

    // State, program counter, run counters and stall watchdog registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            len_q    <= '0;
            issued_q <= '0;
            mem_q    <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            mem_q    <= mem_d;
            stall_q  <= stall_d;
        end
    end

    // Next-state logic: start, handshake accounting, bubble insertion and stall detection
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        len_d    = len_q;
        issued_d = issued_q;
        mem_d    = mem_q;
        stall_d  = '0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    len_d    = len_sat;
                    pc_d     = '0;
                    issued_d = '0;
                    mem_d    = '0;
                    state_d  = (len_sat != '0) ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE: begin
                if (instr_ready_i) begin
                    pc_d     = pc_inc;
                    issued_d = issued_q + ONE_W;
                    if (cur_is_mem) begin
                        mem_d = mem_q + ONE_W;
                    end
                    if (pc_inc == len_q) begin
                        state_d = S_DONE;
                    end else if (cur_is_mem && BUBBLE_EN) begin
                        state_d = S_BUBBLE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else if (stall_q == MAX_STALL_W) begin
                    state_d = S_ERR;
                end else begin
                    stall_d = stall_q + 8'd1;
                end
            end
            S_BUBBLE: begin
                state_d = S_ISSUE;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are pure decodes of registered state; ready never feeds valid
    assign instr_valid_o = (state_q == S_ISSUE);
    assign instr_o       = (state_q == S_ISSUE) ? cur_instr : 32'h0;
    assign busy_o        = (state_q == S_ISSUE) || (state_q == S_BUBBLE);
    assign done_o        = (state_q == S_DONE);
    assign stall_err_o   = (state_q == S_ERR);
    assign issued_cnt_o  = issued_q;
    assign mem_ops_o     = mem_q;

endmodule

// File: tb/tb_lsu_issue_sequencer.sv
// tb/tb_lsu_issue_sequencer.sv - directed self-checking bench for lsu_issue_sequencer
module tb_lsu_issue_sequencer;

    localparam int DEPTH     = 4;
    localparam int IDX_W     = 2;
    localparam int MAX_STALL = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             prog_we_i;
    logic [IDX_W-1:0] prog_addr_i;
    logic [31:0]      prog_data_i;
    logic [IDX_W:0]   prog_len_i;
    logic             start_i;
    logic [31:0]      instr_o;
    logic             instr_valid_o;
    logic             instr_ready_i;
    logic             busy_o;
    logic             done_o;
    logic [IDX_W:0]   issued_cnt_o;
    logic [IDX_W:0]   mem_ops_o;
    logic             stall_err_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] prog [4];
    logic        exp_v [8];
    logic [31:0] exp_i [8];
    int          n_exp;

    lsu_issue_sequencer #(
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W),
        .MAX_STALL (MAX_STALL)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .prog_we_i     (prog_we_i),
        .prog_addr_i   (prog_addr_i),
        .prog_data_i   (prog_data_i),
        .prog_len_i    (prog_len_i),
        .start_i       (start_i),
        .instr_o       (instr_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .issued_cnt_o  (issued_cnt_o),
        .mem_ops_o     (mem_ops_o),
        .stall_err_o   (stall_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles && done_o !== 1'b1; i++) tick();
        check(tag, {31'b0, done_o}, 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, {31'b0, instr_valid_o}, 32'd0);
        check({tag, "_instr"}, instr_o, 32'h0);
        check({tag, "_busy"},  {31'b0, busy_o}, 32'd0);
        check({tag, "_done"},  {31'b0, done_o}, 32'd0);
        check({tag, "_err"},   {31'b0, stall_err_o}, 32'd0);
        check({tag, "_iss"},   {29'b0, issued_cnt_o}, 32'd0);
        check({tag, "_mem"},   {29'b0, mem_ops_o}, 32'd0);
    endtask

    initial begin
        prog[0] = 32'h00002083;
        prog[1] = 32'h00112023;
        prog[2] = 32'h00022183;
        prog[3] = 32'h00000093;

        rst_i = 1'b1; prog_we_i = 1'b0; prog_addr_i = '0; prog_data_i = '0;
        prog_len_i = '0; start_i = 1'b0; instr_ready_i = 1'b1;
        tick(); tick();
        check_idle_outputs("reset");
        rst_i = 1'b0;

        for (int i = 0; i < 4; i++) begin
            prog_we_i = 1'b1; prog_addr_i = 2'(i); prog_data_i = prog[i];
            tick();
        end
        prog_we_i = 1'b0;

        // Full program, ready held high
`ifdef LSU_SEQ_MEM_BUBBLE_EN
        n_exp = 7;
        exp_v[0] = 1; exp_i[0] = prog[0];
        exp_v[1] = 0; exp_i[1] = 32'h0;
        exp_v[2] = 1; exp_i[2] = prog[1];
        exp_v[3] = 0; exp_i[3] = 32'h0;
        exp_v[4] = 1; exp_i[4] = prog[2];
        exp_v[5] = 0; exp_i[5] = 32'h0;
        exp_v[6] = 1; exp_i[6] = prog[3];
`else
        n_exp = 4;
        for (int i = 0; i < 4; i++) begin
            exp_v[i] = 1; exp_i[i] = prog[i];
        end
`endif
        prog_len_i = 3'd4; start_i = 1'b1; instr_ready_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < n_exp; i++) begin
            check($sformatf("run_valid_%0d", i), {31'b0, instr_valid_o}, {31'b0, exp_v[i]});
            check($sformatf("run_instr_%0d", i), instr_o, exp_i[i]);
            check($sformatf("run_busy_%0d", i),  {31'b0, busy_o}, 32'd1);
            tick();
        end
        check("run_done",   {31'b0, done_o}, 32'd1);
        check("run_busy",   {31'b0, busy_o}, 32'd0);
        check("run_valid",  {31'b0, instr_valid_o}, 32'd0);
        check("run_issued", {29'b0, issued_cnt_o}, 32'd4);
        check("run_memops", {29'b0, mem_ops_o}, 32'd3);

        // Backpressure on entry 1 for three cycles; restart from DONE
        start_i = 1'b1; instr_ready_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("bp_entry0", instr_o, prog[0]);
        tick();
`ifdef LSU_SEQ_MEM_BUBBLE_EN
        check("bp_bubble", {31'b0, instr_valid_o}, 32'd0);
        tick();
`endif
        instr_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_hold_valid_%0d", i), {31'b0, instr_valid_o}, 32'd1);
            check($sformatf("bp_hold_instr_%0d", i), instr_o, prog[1]);
            tick();
        end
        instr_ready_i = 1'b1;
        check("bp_accept_valid", {31'b0, instr_valid_o}, 32'd1);
        check("bp_accept_instr", instr_o, prog[1]);
        tick();
        check("bp_issued", {29'b0, issued_cnt_o}, 32'd2);
        check("bp_no_err", {31'b0, stall_err_o}, 32'd0);
        wait_done("bp_done", 10);
        check("bp_no_err_end", {31'b0, stall_err_o}, 32'd0);

        // Buffer writes are ignored while running: attempt one during issue
        start_i = 1'b1; instr_ready_i = 1'b0;
        tick();
        start_i = 1'b0;
        prog_we_i = 1'b1; prog_addr_i = 2'd0; prog_data_i = 32'hDEADBEEF;
        check("stall_v0_instr", instr_o, prog[0]);
        for (int i = 0; i < MAX_STALL + 1; i++) begin
            check($sformatf("stall_valid_%0d", i), {31'b0, instr_valid_o}, 32'd1);
            check($sformatf("stall_err_%0d", i),   {31'b0, stall_err_o}, 32'd0);
            check($sformatf("stall_instr_%0d", i), instr_o, prog[0]);
            tick();
            prog_we_i = 1'b0;
        end
        check("stall_err_set", {31'b0, stall_err_o}, 32'd1);
        check("stall_valid_drop", {31'b0, instr_valid_o}, 32'd0);
        check("stall_busy", {31'b0, busy_o}, 32'd0);
        start_i = 1'b1; prog_len_i = 3'd4; instr_ready_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        check("err_sticky", {31'b0, stall_err_o}, 32'd1);
        check("err_no_valid", {31'b0, instr_valid_o}, 32'd0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_idle_outputs("err_reset");

        // Zero-length program
        prog_len_i = 3'd0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("len0_done",  {31'b0, done_o}, 32'd1);
        check("len0_valid", {31'b0, instr_valid_o}, 32'd0);
        check("len0_iss",   {29'b0, issued_cnt_o}, 32'd0);
        check("len0_mem",   {29'b0, mem_ops_o}, 32'd0);

        // Oversized length saturates to DEPTH; entry 0 kept its pre-run value
        prog_len_i = 3'd7; start_i = 1'b1; instr_ready_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("sat_entry0", instr_o, prog[0]);
        wait_done("sat_done", 12);
        check("sat_issued", {29'b0, issued_cnt_o}, 32'd4);
        check("sat_mem",    {29'b0, mem_ops_o}, 32'd3);

        // Reset one cycle after entry 0 is accepted (bubble when enabled)
        prog_len_i = 3'd4; start_i = 1'b1; instr_ready_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
`ifdef LSU_SEQ_MEM_BUBBLE_EN
        check("rstb_in_bubble", {31'b0, instr_valid_o}, 32'd0);
`else
        check("rstb_entry1", instr_o, prog[1]);
`endif
        check("rstb_busy", {31'b0, busy_o}, 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_idle_outputs("rstb");
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("rstb_restart_valid", {31'b0, instr_valid_o}, 32'd1);
        check("rstb_restart_instr", instr_o, prog[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
